branch_pc_sequencer: RTL and testbench

//  Program-counter sequencer for the single-cycle CPU that owns a runtime-

---
 rtl/branch_pc_sequencer.sv | 119 +++++++++++
 tb/tb_branch_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pc_sequencer.sv
// ============================================================================
// Module      : branch_pc_sequencer
// Description : PC sequencer with a runtime-programmable 4-entry branch table
//               and a saturating instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pc_sequencer #(
    parameter int                  PC_W     = 8,
    parameter logic [PC_W-1:0]     START_PC = '0,
    parameter logic [4*PC_W-1:0]   TGT_INIT = 32'h30_20_10_08,
    parameter int                  CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [1:0]       branch_sel,
    input  logic             halt_req,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_idx,
    input  logic [PC_W-1:0]  cfg_data,
    output logic             cfg_ready,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [PC_W-1:0]  r_tbl [4];
    logic [PC_W-1:0]  w_tgt;
    logic             w_cfg_ready;
    logic             w_cfg_wr;

    assign w_cfg_ready = (r_state != S_RUN);
    assign w_cfg_wr    = cfg_valid & w_cfg_ready;
    assign w_tgt       = r_tbl[branch_sel];
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : (r_cnt + c_CNT_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= START_PC;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Writes are only accepted outside RUN, so a branch never races a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_tbl[i] <= TGT_INIT[i*PC_W +: PC_W];
            end
        end else if (w_cfg_wr) begin
            r_tbl[cfg_idx] <= cfg_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = START_PC;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (halt_req) begin
                        w_state_nxt = S_DONE;
                    end else if (branch_en) begin
                        w_pc_nxt = w_tgt;
                    end else begin
                        w_pc_nxt = r_pc + c_PC_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cfg_ready   = w_cfg_ready;
    assign pc          = r_pc;
    assign running     = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign instr_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_branch_pc_sequencer.sv
// ============================================================================
// Module      : tb_branch_pc_sequencer
// Description : Scoreboard bench for branch_pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_pc_sequencer;

    localparam int c_IDLE = 0;
    localparam int c_RUN  = 1;
    localparam int c_DONE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stall, branch_en, halt_req, cfg_valid;
    logic [1:0] branch_sel, cfg_idx;
    logic [7:0] cfg_data;
    logic       cfg_ready, running, done;
    logic [7:0] pc;
    logic [15:0] instr_count;

    logic       s_cfg_ready, s_running, s_done;
    logic [7:0] s_pc;
    logic [3:0] s_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  pc;
        logic        running;
        logic        done;
        logic        cfg_ready;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t sb_q[$];

    int         m_state;
    logic [7:0] m_pc;
    logic [15:0] m_cnt;
    logic [3:0] m_cnt4;
    logic [7:0] m_tbl [4];

    always #5 clk = ~clk;

    branch_pc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_en(branch_en), .branch_sel(branch_sel), .halt_req(halt_req),
        .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .pc(pc), .running(running), .done(done),
        .instr_count(instr_count)
    );

    // Narrow counter copy so saturation is reachable in a short run.
    branch_pc_sequencer #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_en(branch_en), .branch_sel(branch_sel), .halt_req(halt_req),
        .cfg_valid(cfg_valid), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .cfg_ready(s_cfg_ready), .pc(s_pc), .running(s_running), .done(s_done),
        .instr_count(s_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = c_IDLE;
        m_pc    = 8'h00;
        m_cnt   = '0;
        m_cnt4  = '0;
        m_tbl[0] = 8'h08; m_tbl[1] = 8'h10; m_tbl[2] = 8'h20; m_tbl[3] = 8'h30;
    endtask

    task automatic model_step(input logic st, sl, be, input logic [1:0] bs,
                              input logic hr, cv, input logic [1:0] ci,
                              input logic [7:0] cd);
        exp_t e;
        if (m_state == c_RUN) begin
            if (!sl) begin
                if (m_cnt  != 16'hFFFF) m_cnt  = m_cnt + 16'd1;
                if (m_cnt4 != 4'hF)     m_cnt4 = m_cnt4 + 4'd1;
                if (hr)      m_state = c_DONE;
                else if (be) m_pc = m_tbl[bs];
                else         m_pc = m_pc + 8'd1;
            end
        end else begin
            if (cv) m_tbl[ci] = cd;
            if (st) begin
                m_state = c_RUN;
                m_pc    = 8'h00;
                m_cnt   = '0;
                m_cnt4  = '0;
            end
        end
        e.pc        = m_pc;
        e.running   = (m_state == c_RUN);
        e.done      = (m_state == c_DONE);
        e.cfg_ready = (m_state != c_RUN);
        e.cnt       = m_cnt;
        e.cnt4      = m_cnt4;
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "_pc"},    {24'd0, pc},          {24'd0, e.pc});
        check({tag, "_flags"}, {29'd0, running, done, cfg_ready},
                               {29'd0, e.running, e.done, e.cfg_ready});
        check({tag, "_cnt"},   {16'd0, instr_count}, {16'd0, e.cnt});
        check({tag, "_cnt4"},  {28'd0, s_count},     {28'd0, e.cnt4});
    endtask

    task automatic cyc(input string tag, input logic st, sl, be, input logic [1:0] bs,
                       input logic hr, cv, input logic [1:0] ci, input logic [7:0] cd);
        start = st; stall = sl; branch_en = be; branch_sel = bs;
        halt_req = hr; cfg_valid = cv; cfg_idx = ci; cfg_data = cd;
        model_step(st, sl, be, bs, hr, cv, ci, cd);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic plain(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 2'd0, 0, 0, 2'd0, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        start = 0; stall = 0; branch_en = 0; branch_sel = 0;
        halt_req = 0; cfg_valid = 0; cfg_idx = 0; cfg_data = 0;
        reset = 1'b1;
        model_reset();
        #12;
        reset = 1'b0;
        @(negedge clk);
        check("rst_pc",    {24'd0, pc}, 32'h00);
        check("rst_flags", {29'd0, running, done, cfg_ready}, 32'b001);
        check("rst_cnt",   {16'd0, instr_count}, 32'd0);
        @(posedge clk);
        #1;

        // T1
        cyc("t1_start", 1, 0, 0, 2'd0, 0, 0, 2'd0, 8'h00);
        check("t1_pc0", {24'd0, pc}, 32'h00);
        plain("t1_run", 5);
        check("t1_pc5", {24'd0, pc}, 32'h05);
        check("t1_cnt5", {16'd0, instr_count}, 32'd5);
        check("t1_ready0", {31'd0, cfg_ready}, 32'd0);
        cyc("t1_start_ign", 1, 0, 0, 2'd0, 0, 0, 2'd0, 8'h00);

        // T2: reach FE through a programmed entry, then wrap
        cyc("t2_halt", 0, 0, 0, 2'd0, 1, 0, 2'd0, 8'h00);
        cyc("t2_cfg",  0, 0, 0, 2'd0, 0, 1, 2'd3, 8'hFE);
        cyc("t2_start", 1, 0, 0, 2'd0, 0, 0, 2'd0, 8'h00);
        cyc("t2_br", 0, 0, 1, 2'd3, 0, 0, 2'd0, 8'h00);
        check("t2_pcFE", {24'd0, pc}, 32'hFE);
        plain("t2_wrap", 3);
        check("t2_pc01", {24'd0, pc}, 32'h01);
        cyc("t2_xsel", 0, 0, 0, 2'bxx, 0, 0, 2'd0, 8'h00);
        check("t2_xsel_pc", {24'd0, pc}, 32'h02);

        // T3: same-cycle write and start from IDLE
        do_reset();
        cyc("t3_wr_start", 1, 0, 0, 2'd0, 0, 1, 2'd2, 8'h5A);
        cyc("t3_br2", 0, 0, 1, 2'd2, 0, 0, 2'd0, 8'h00);
        check("t3_pc5A", {24'd0, pc}, 32'h5A);
        cyc("t3_br1", 0, 0, 1, 2'd1, 0, 0, 2'd0, 8'h00);
        check("t3_pc10", {24'd0, pc}, 32'h10);

        // T4: stall dominates halt and branch
        cyc("t4_stall", 0, 1, 1, 2'd3, 1, 0, 2'd0, 8'h00);
        check("t4_hold_pc", {24'd0, pc}, 32'h10);
        check("t4_run", {30'd0, running, done}, 32'b10);
        cyc("t4_halt", 0, 0, 0, 2'd0, 1, 0, 2'd0, 8'h00);
        check("t4_done", {30'd0, running, done}, 32'b01);
        check("t4_pc", {24'd0, pc}, 32'h10);

        // T5
        cyc("t5_start", 1, 0, 0, 2'd0, 0, 0, 2'd0, 8'h00);
        plain("t5_run", 6);
        cyc("t5_halt", 0, 0, 0, 2'd0, 1, 0, 2'd0, 8'h00);
        check("t5_cnt7", {16'd0, instr_count}, 32'd7);
        plain("t5_done_hold", 2);
        cyc("t5_cfg", 0, 0, 0, 2'd0, 0, 1, 2'd0, 8'hC3);
        cyc("t5_start2", 1, 0, 0, 2'd0, 0, 0, 2'd0, 8'h00);
        check("t5_cnt0", {16'd0, instr_count}, 32'd0);
        cyc("t5_br0", 0, 0, 1, 2'd0, 0, 0, 2'd0, 8'h00);
        check("t5_pcC3", {24'd0, pc}, 32'hC3);
        cyc("t5_cfg_run", 0, 0, 0, 2'd0, 0, 1, 2'd0, 8'h11);
        cyc("t5_br0b", 0, 0, 1, 2'd0, 0, 0, 2'd0, 8'h00);
        check("t5_tbl_kept", {24'd0, pc}, 32'hC3);

        // Saturation of the narrow counter
        plain("sat_run", 16);
        check("sat_cnt4", {28'd0, s_count}, 32'hF);

        // T6: asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        check("t6_async_pc", {24'd0, pc}, 32'h00);
        check("t6_async_flags", {29'd0, running, done, cfg_ready}, 32'b001);
        check("t6_async_cnt", {16'd0, instr_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("t6_start", 1, 0, 0, 2'd0, 0, 0, 2'd0, 8'h00);
        cyc("t6_br2", 0, 0, 1, 2'd2, 0, 0, 2'd0, 8'h00);
        check("t6_pc20", {24'd0, pc}, 32'h20);
        cyc("t6_br0", 0, 0, 1, 2'd0, 0, 0, 2'd0, 8'h00);
        check("t6_pc08", {24'd0, pc}, 32'h08);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
